// File: rtl/result_fifo_1210708.sv
// Registered output stage of the multifunction ALU: buffers signed results with their
// operation select and zero/negative/overflow status behind a valid/ready handshake.
module result_fifo_1210708 #(
  parameter int N     = 4,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N+1:0]             in_result,
  input  logic [2:0]               in_sel,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [N+1:0]             out_result,
  output logic [2:0]               out_sel,
  output logic                     out_zero,
  output logic                     out_neg,
  output logic                     out_ovf,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overrun
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [N+1:0]  r_mem_result [DEPTH];
  logic [2:0]    r_mem_sel    [DEPTH];
  logic [2:0]    r_mem_flags  [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_overrun;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;
  logic w_zero;
  logic w_neg;
  logic w_ovf;

  assign w_full    = (r_count == FULL_COUNT);
  assign w_empty   = (r_count == '0);
  assign in_ready  = !w_full;
  assign out_valid = !w_empty;
  assign w_push    = in_valid && !w_full;
  assign w_pop     = !w_empty && out_ready;

  // A result fits the N-bit signed range exactly when its top three bits agree.
  assign w_zero = (in_result == '0);
  assign w_neg  = in_result[N+1];
  assign w_ovf  = !((in_result[N+1:N-1] == '0) || (in_result[N+1:N-1] == '1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (in_valid && w_full) r_overrun <= 1'b1;
    end
  end

  // NOTE: storage has no reset; its contents are never visible while count is 0.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_result[r_wr_ptr] <= in_result;
      r_mem_sel[r_wr_ptr]    <= in_sel;
      r_mem_flags[r_wr_ptr]  <= {w_zero, w_neg, w_ovf};
    end
  end

  always_comb begin
    out_result = '0;
    out_sel    = '0;
    out_zero   = 1'b0;
    out_neg    = 1'b0;
    out_ovf    = 1'b0;
    if (out_valid) begin
      out_result                   = r_mem_result[r_rd_ptr];
      out_sel                      = r_mem_sel[r_rd_ptr];
      {out_zero, out_neg, out_ovf} = r_mem_flags[r_rd_ptr];
    end
  end

  assign count   = r_count;
  assign overrun = r_overrun;

endmodule
